debug_output_monitor: RTL

- Parametrised, clocked successor to the processor's combinational debug output logic.
- Probes the shared data bus (BUS), the register-file second read port (REG) and the controller timestep (TIME), and drives LEDs and 7-segment displays.
- Adds four display modes: live bus, manual register peek, automatic register scan, and a last-result freeze capture.
- Stretches the one-cycle DONE (Clr) pulse so it is visible on an LED.
- Sits beside the controller and register file; it owns the register file's second read address.

---
 rtl/debug_output_monitor.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/debug_output_monitor.sv
// Registered debug display: probes the shared bus, register-file read port 2 and
// controller timestep, and drives LEDs and active-low 7-segment digits in four modes
// (live bus, register peek, register scan, last-result freeze). Also stretches DONE.
module debug_output_monitor #(
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned TIME_W    = 2,
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned DWELL     = 50_000_000,
    parameter int unsigned DONE_HOLD = 25_000_000,
    localparam int unsigned NUM_DIGITS = (DATA_W + 3) / 4,
    localparam int unsigned ADDR_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int unsigned DHEX_W     = 7 * NUM_DIGITS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] bus_i,
    input  logic [DATA_W-1:0] reg_i,
    input  logic [TIME_W-1:0] time_i,
    input  logic              done_i,
    input  logic [1:0]        mode_i,
    input  logic [ADDR_W-1:0] peek_addr_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] led_b_o,
    output logic              led_d_o,
    output logic [DHEX_W-1:0] dhex_o,
    output logic [6:0]        ahex_o,
    output logic [6:0]        thex_o
);

    localparam int unsigned PAD_W   = 4 * NUM_DIGITS;
    localparam int unsigned DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned HOLD_W  = (DONE_HOLD > 0) ? $clog2(DONE_HOLD + 1) : 1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] MODE_BUS    = 2'd0;
    localparam logic [1:0] MODE_PEEK   = 2'd1;
    localparam logic [1:0] MODE_SCAN   = 2'd2;
    localparam logic [1:0] MODE_FREEZE = 2'd3;

    // Active-low segment pattern for one nibble, bit0 = a .. bit6 = g.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Whole data word to a row of digits; top digit zero-extended.
    function automatic logic [DHEX_W-1:0] hex_word(input logic [DATA_W-1:0] val);
        logic [PAD_W-1:0]  pad;
        logic [DHEX_W-1:0] segs;
        pad  = PAD_W'(val);
        segs = '0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            segs[7*k +: 7] = seg7(pad[4*k +: 4]);
        end
        return segs;
    endfunction

    logic [1:0]         mode_q,    mode_d;
    logic [ADDR_W-1:0]  scan_idx_q, scan_idx_d;
    logic [DWELL_W-1:0] dwell_q,   dwell_d;
    logic [HOLD_W-1:0]  hold_q,    hold_d;
    logic [DATA_W-1:0]  cap_q,     cap_d;
    logic               cap_vld_q, cap_vld_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]  led_b_q,   led_b_d;
    logic               led_d_q,   led_d_d;
    logic [DHEX_W-1:0]  dhex_q,    dhex_d;
    logic [6:0]         ahex_q,    ahex_d;
    logic [6:0]         thex_q,    thex_d;

    // Next-state for scan, capture, DONE stretch and all display registers.
    always_comb begin
        mode_d     = mode_i;
        scan_idx_d = scan_idx_q;
        dwell_d    = dwell_q;
        hold_d     = hold_q;
        cap_d      = cap_q;
        cap_vld_d  = cap_vld_q;
        rd_addr_d  = peek_addr_i;
        led_b_d    = bus_i;
        led_d_d    = done_i | (hold_q != '0);
        dhex_d     = {NUM_DIGITS{SEG_BLANK}};
        ahex_d     = SEG_BLANK;
        thex_d     = seg7(4'(time_i));

        // Capture runs in every mode so FREEZE always has the latest result.
        if (done_i) begin
            cap_d     = bus_i;
            cap_vld_d = 1'b1;
        end

        // Retrigger reloads; otherwise count down to zero.
        if (done_i) begin
            hold_d = HOLD_W'(DONE_HOLD);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end

        // Scan restarts from register 0 whenever SCAN is newly entered.
        if (mode_i == MODE_SCAN) begin
            if (mode_q != MODE_SCAN) begin
                scan_idx_d = '0;
                dwell_d    = '0;
            end else if (dwell_q == DWELL_W'(DWELL - 1)) begin
                dwell_d    = '0;
                scan_idx_d = (scan_idx_q == ADDR_W'(NUM_REGS - 1)) ? '0
                                                                   : scan_idx_q + ADDR_W'(1);
            end else begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
        end

        case (mode_i)
            MODE_BUS: begin
                dhex_d = hex_word(bus_i);
            end
            MODE_PEEK: begin
                dhex_d = hex_word(reg_i);
                ahex_d = seg7(4'(peek_addr_i));
            end
            MODE_SCAN: begin
                rd_addr_d = scan_idx_d;
                dhex_d    = hex_word(reg_i);
                ahex_d    = seg7(4'(scan_idx_d));
            end
            MODE_FREEZE: begin
                if (cap_vld_d) begin
                    dhex_d = hex_word(cap_d);
                end
            end
            default: begin
                dhex_d = {NUM_DIGITS{SEG_BLANK}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q     <= MODE_BUS;
            scan_idx_q <= '0;
            dwell_q    <= '0;
            hold_q     <= '0;
            cap_q      <= '0;
            cap_vld_q  <= 1'b0;
            rd_addr_q  <= '0;
            led_b_q    <= '0;
            led_d_q    <= 1'b0;
            dhex_q     <= {NUM_DIGITS{SEG_BLANK}};
            ahex_q     <= SEG_BLANK;
            thex_q     <= SEG_BLANK;
        end else begin
            mode_q     <= mode_d;
            scan_idx_q <= scan_idx_d;
            dwell_q    <= dwell_d;
            hold_q     <= hold_d;
            cap_q      <= cap_d;
            cap_vld_q  <= cap_vld_d;
            rd_addr_q  <= rd_addr_d;
            led_b_q    <= led_b_d;
            led_d_q    <= led_d_d;
            dhex_q     <= dhex_d;
            ahex_q     <= ahex_d;
            thex_q     <= thex_d;
        end
    end

    assign rd_addr_o = rd_addr_q;
    assign led_b_o   = led_b_q;
    assign led_d_o   = led_d_q;
    assign dhex_o    = dhex_q;
    assign ahex_o    = ahex_q;
    assign thex_o    = thex_q;

endmodule
